// File: rtl/shift_pipe_if.sv
// Valid/ready stream bundle for shift_pipe: operation going in, shifted result coming out.
interface shift_pipe_if #(parameter int WIDTH = 32);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shamt;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;

  modport master (
    output in_valid, in_data, in_shamt, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, out_ready,
    output in_ready, out_valid, out_data, out_zero
  );
endinterface

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter: stage k applies a 2^k step when shamt bit k is set.
// The whole pipe advances together under a single global stall.
module shift_pipe #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  shift_pipe_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } op_e;

  logic advance;
  logic last_valid;

  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                  input logic [1:0] op,
                                                  input logic sign,
                                                  input int amt);
    logic [WIDTH-1:0] fill;
    // SRA fills from the operand's original MSB, carried alongside the op
    fill = {WIDTH{sign}} << (WIDTH - amt);
    case (op_e'(op))
      OP_SLL:  shift_step = d << amt;
      OP_SRL:  shift_step = d >> amt;
      OP_SRA:  shift_step = (d >> amt) | fill;
      default: shift_step = (d << amt) | (d >> (WIDTH - amt));
    endcase
  endfunction

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [SHW-1:0]   shamt_q;
    logic [1:0]       op_q;
    logic             sign_q;

    logic             src_valid;
    logic [WIDTH-1:0] src_data;
    logic [SHW-1:0]   src_shamt;
    logic [1:0]       src_op;
    logic             src_sign;

    if (k == 0) begin : g_head
      assign src_valid = bus.in_valid;
      assign src_data  = bus.in_data;
      assign src_shamt = bus.in_shamt;
      assign src_op    = bus.in_op;
      assign src_sign  = bus.in_data[WIDTH-1];
    end else begin : g_body
      assign src_valid = g_stage[k-1].valid_q;
      assign src_data  = g_stage[k-1].data_q;
      assign src_shamt = g_stage[k-1].shamt_q;
      assign src_op    = g_stage[k-1].op_q;
      assign src_sign  = g_stage[k-1].sign_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        shamt_q <= '0;
        op_q    <= '0;
        sign_q  <= 1'b0;
      end else if (advance) begin
        valid_q <= src_valid;
        data_q  <= src_shamt[k] ? shift_step(src_data, src_op, src_sign, 1 << k) : src_data;
        shamt_q <= src_shamt;
        op_q    <= src_op;
        sign_q  <= src_sign;
      end
    end
  end

  // Control fields in the final stage have no consumer
  logic unused_tail;
  assign unused_tail = ^{g_stage[SHW-1].shamt_q, g_stage[SHW-1].op_q, g_stage[SHW-1].sign_q};

  assign last_valid    = g_stage[SHW-1].valid_q;
  assign advance       = !last_valid || bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = last_valid;
  assign bus.out_data  = g_stage[SHW-1].data_q;
  assign bus.out_zero  = (g_stage[SHW-1].data_q == '0);
endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe: directed vectors, corner sequences and a random
// run on 32-bit and 8-bit instances against an arithmetic reference model.
module tb_shift_pipe;
  logic clk = 1'b0;
  logic rst = 1'b0;

  shift_pipe_if #(.WIDTH(32)) bus32();
  shift_pipe_if #(.WIDTH(8))  bus8();

  shift_pipe #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  shift_pipe #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [1:0]  op;
    logic [31:0] expected;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [63:0] q32[$];
  logic [63:0] q8[$];
  logic [63:0] exp_v;
  logic [31:0] hold32;
  logic [7:0]  hold8;
  bit          stall32, stall8;
  int          lat, got, low_cnt, next_op, stall_left, ops32, ops8;
  bit          seen_first, any_valid;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] data, input logic [4:0] shamt,
                               input logic [1:0] op, input logic ready);
    bus32.in_valid  = valid;
    bus32.in_data   = data;
    bus32.in_shamt  = shamt;
    bus32.in_op     = op;
    bus32.out_ready = ready;
  endtask

  // Reference: plain arithmetic on a 64-bit container, masked to w bits
  function automatic logic [63:0] ref_shift(input logic [63:0] d, input int n, input logic [1:0] op, input int w);
    logic [63:0]        mask;
    logic [63:0]        r;
    logic signed [63:0] sx;
    mask = (64'd1 << w) - 64'd1;
    d = d & mask;
    case (op)
      2'd0: r = (d << n) & mask;
      2'd1: r = d >> n;
      2'd2: begin
        sx = $signed(d << (64 - w));
        sx = sx >>> (64 - w);
        r  = (sx >>> n) & mask;
      end
      default: r = (n == 0) ? d : (((d << n) | (d >> (w - n))) & mask);
    endcase
    return r;
  endfunction

  initial begin
    applyStimulus(0, 0, 0, 0, 1);
    bus8.in_valid = 0; bus8.in_data = 0; bus8.in_shamt = 0; bus8.in_op = 0; bus8.out_ready = 1;

    vecs.push_back('{"sll_1_by_31",  32'h0000_0001, 5'd31, 2'd0, 32'h8000_0000});
    vecs.push_back('{"srl_msb_by_4", 32'h8000_0000, 5'd4,  2'd1, 32'h0800_0000});
    vecs.push_back('{"sra_msb_by_4", 32'h8000_0000, 5'd4,  2'd2, 32'hF800_0000});
    vecs.push_back('{"rol_by_1",     32'h8000_0001, 5'd1,  2'd3, 32'h0000_0003});
    vecs.push_back('{"sll_by_0",     32'hFFFF_FFFF, 5'd0,  2'd0, 32'hFFFF_FFFF});
    vecs.push_back('{"srl_to_zero",  32'h0000_000F, 5'd4,  2'd1, 32'h0000_0000});
    vecs.push_back('{"sra_pos_by_3", 32'h7000_0000, 5'd3,  2'd2, 32'h0E00_0000});
    vecs.push_back('{"rol_by_31",    32'h8000_0000, 5'd31, 2'd3, 32'h4000_0000});

    #1 rst = 1'b1;
    #1;
    checkOutput("reset_out_valid", bus32.out_valid, 0);
    checkOutput("reset_out_data",  bus32.out_data, 0);
    checkOutput("reset_out_zero",  bus32.out_zero, 1);
    checkOutput("reset_in_ready",  bus32.in_ready, 1);
    @(negedge clk) rst = 1'b0;

    // Directed vectors: latency counted with the accept cycle as cycle 1
    foreach (vecs[i]) begin
      @(negedge clk) applyStimulus(1, vecs[i].data, vecs[i].shamt, vecs[i].op, 1);
      @(posedge clk);
      @(negedge clk) applyStimulus(0, 0, 0, 0, 1);
      lat = 1;
      while (!bus32.out_valid && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      checkOutput({vecs[i].name, "_valid"},   bus32.out_valid, 1);
      checkOutput({vecs[i].name, "_latency"}, lat, 5);
      checkOutput({vecs[i].name, "_data"},    bus32.out_data, vecs[i].expected);
      checkOutput({vecs[i].name, "_zero"},    bus32.out_zero, vecs[i].expected == 0);
      @(posedge clk);
    end

    // Backpressure: 8 back-to-back SLL-by-1 ops, 3-cycle stall at the first result
    next_op = 1; got = 0; low_cnt = 0; stall_left = 0; seen_first = 0; stall32 = 0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      @(negedge clk);
      if (!seen_first && bus32.out_valid) begin
        seen_first = 1;
        stall_left = 3;
      end
      applyStimulus(next_op <= 8, next_op, 5'd1, 2'd0, stall_left == 0);
      #1;
      if (!bus32.in_ready) low_cnt++;
      if (stall32) checkOutput("bp_hold", bus32.out_data, hold32);
      if (bus32.out_valid && bus32.out_ready) begin
        got++;
        checkOutput("bp_order", bus32.out_data, 2 * got);
      end
      stall32 = bus32.out_valid && !bus32.out_ready;
      hold32  = bus32.out_data;
      if (bus32.in_valid && bus32.in_ready) next_op++;
      if (stall_left > 0) stall_left--;
    end
    checkOutput("bp_count", got, 8);
    checkOutput("bp_in_ready_low_cycles", low_cnt, 3);
    @(negedge clk) applyStimulus(0, 0, 0, 0, 1);
    #1 checkOutput("bp_drained", bus32.out_valid, 0);

    // Asynchronous reset mid-cycle while a result is being held
    @(negedge clk) applyStimulus(1, 32'h5, 5'd0, 2'd0, 0);
    @(negedge clk) applyStimulus(0, 0, 0, 0, 0);
    for (int c = 0; c < 10 && !bus32.out_valid; c++) @(negedge clk);
    checkOutput("pre_reset_valid", bus32.out_valid, 1);
    checkOutput("pre_reset_in_ready", bus32.in_ready, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_reset_out_valid", bus32.out_valid, 0);
    checkOutput("async_reset_out_zero",  bus32.out_zero, 1);
    checkOutput("async_reset_in_ready",  bus32.in_ready, 1);
    @(negedge clk) begin rst = 1'b0; applyStimulus(0, 0, 0, 0, 1); end

    // Reset while three ops are in flight: none of them may emerge
    for (int i = 0; i < 3; i++) @(negedge clk) applyStimulus(1, 32'hA0 + i, 5'd2, 2'd0, 1);
    @(negedge clk) applyStimulus(0, 0, 0, 0, 1);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    any_valid = 0;
    for (int c = 0; c < 10; c++) @(negedge clk) any_valid |= bus32.out_valid;
    checkOutput("flush_no_ghost", any_valid, 0);
    applyStimulus(1, 32'h8000_0001, 5'd1, 2'd3, 1);
    @(negedge clk) applyStimulus(0, 0, 0, 0, 1);
    for (int c = 0; c < 10 && !bus32.out_valid; c++) @(negedge clk);
    checkOutput("post_flush_valid", bus32.out_valid, 1);
    checkOutput("post_flush_data",  bus32.out_data, 32'h3);
    @(posedge clk);

    // 8-bit instance: sign fill all the way down
    @(negedge clk) begin
      bus8.in_valid = 1; bus8.in_data = 8'h80; bus8.in_shamt = 3'd7; bus8.in_op = 2'd2; bus8.out_ready = 1;
    end
    @(negedge clk) bus8.in_valid = 0;
    for (int c = 0; c < 10 && !bus8.out_valid; c++) @(negedge clk);
    checkOutput("w8_sra_valid", bus8.out_valid, 1);
    checkOutput("w8_sra_80_by_7", bus8.out_data, 8'hFF);
    @(posedge clk);

    // Random traffic on both widths with random backpressure
    stall32 = 0; stall8 = 0; ops32 = 0; ops8 = 0;
    for (int c = 0; c < 14000; c++) begin
      @(negedge clk);
      applyStimulus($urandom_range(0, 7) != 0, $urandom, 5'($urandom_range(0, 31)),
                    2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
      bus8.in_valid  = $urandom_range(0, 7) != 0;
      bus8.in_data   = 8'($urandom_range(0, 255));
      bus8.in_shamt  = 3'($urandom_range(0, 7));
      bus8.in_op     = 2'($urandom_range(0, 3));
      bus8.out_ready = $urandom_range(0, 3) != 0;
      #1;
      checkOutput("rnd32_in_ready", bus32.in_ready, !bus32.out_valid || bus32.out_ready);
      if (stall32) begin
        checkOutput("rnd32_stall_valid", bus32.out_valid, 1);
        checkOutput("rnd32_stall_hold", bus32.out_data, hold32);
      end
      if (bus32.out_valid && bus32.out_ready) begin
        exp_v = (q32.size() != 0) ? q32.pop_front() : 64'hDEAD_0000_0000;
        checkOutput("rnd32_data", bus32.out_data, exp_v);
        checkOutput("rnd32_zero", bus32.out_zero, exp_v == 0);
      end
      stall32 = bus32.out_valid && !bus32.out_ready;
      hold32  = bus32.out_data;
      if (bus32.in_valid && bus32.in_ready) begin
        q32.push_back(ref_shift(64'(bus32.in_data), int'(bus32.in_shamt), bus32.in_op, 32));
        ops32++;
      end

      if (stall8) checkOutput("rnd8_stall_hold", bus8.out_data, hold8);
      if (bus8.out_valid && bus8.out_ready) begin
        exp_v = (q8.size() != 0) ? q8.pop_front() : 64'hDEAD_0000_0000;
        checkOutput("rnd8_data", bus8.out_data, exp_v);
        checkOutput("rnd8_zero", bus8.out_zero, exp_v == 0);
      end
      stall8 = bus8.out_valid && !bus8.out_ready;
      hold8  = bus8.out_data;
      if (bus8.in_valid && bus8.in_ready) begin
        q8.push_back(ref_shift(64'(bus8.in_data), int'(bus8.in_shamt), bus8.in_op, 8));
        ops8++;
      end
    end

    // Drain whatever is still in flight
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 1);
      bus8.in_valid = 0; bus8.out_ready = 1;
      #1;
      if (bus32.out_valid) begin
        exp_v = (q32.size() != 0) ? q32.pop_front() : 64'hDEAD_0000_0000;
        checkOutput("drain32_data", bus32.out_data, exp_v);
      end
      if (bus8.out_valid) begin
        exp_v = (q8.size() != 0) ? q8.pop_front() : 64'hDEAD_0000_0000;
        checkOutput("drain8_data", bus8.out_data, exp_v);
      end
    end
    checkOutput("drain32_empty", q32.size(), 0);
    checkOutput("drain8_empty", q8.size(), 0);
    $display("[TB] random ops issued: %0d (32-bit), %0d (8-bit)", ops32, ops8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/shift_pipe.md
# shift_pipe

Parametrised, pipelined barrel shifter for the datapath: shifts or rotates a WIDTH-bit operand by a runtime amount in one of four modes. It generalises the lab's combinational 32-bit SLL into a log2(WIDTH)-stage registered pipeline with a valid/ready stream interface. It sits between operand issue and the ALU result mux, and can accept one operation per cycle.

## Interface

- WIDTH, 32, operand width; power of two, 4..64.
- SHW, $clog2(WIDTH) (derived localparam, not overridable), shift-amount width and pipeline depth.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation presented on in_* this cycle.
- in_ready  output  1  block accepts the operation this cycle.
- in_data  input  WIDTH  operand.
- in_shamt  input  SHW  shift amount, 0..WIDTH-1.
- in_op  input  2  mode: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
- out_valid  output  1  result present on out_*.
- out_ready  input  1  consumer takes the result this cycle.
- out_data  output  WIDTH  shifted result.
- out_zero  output  1  out_data == 0.

## Operation

- Transfer in: in_valid && in_ready at the clock edge. Transfer out: out_valid && out_ready.
- SHW stages, numbered 0..SHW-1. Stage k registers {valid, data, remaining shamt bits, op}. If shamt[k] is set, it applies a shift of 2^k in the stage's mode; otherwise data passes unchanged.
- Mode rules for a 2^k step:
  - SLL: low bits zero-filled.
  - SRL: high bits zero-filled.
  - SRA: high bits filled with the operand's original MSB. The sign is carried with the op, not re-read from the partially shifted data.
  - ROL: bits leaving the MSB re-enter at the LSB.
- Amount 0 in any mode: out_data = in_data.
- There is no right-rotate mode. Callers issue ROL by (WIDTH - n) mod WIDTH instead.
- The output is the last stage's register. out_zero is derived combinationally from out_data.
- Flow control uses a global stall:
  - advance = !out_valid || out_ready.
  - in_ready = advance.
  - When advance is 0, every stage register holds its contents.
  - When advance is 1, every stage shifts forward one position and stage 0 loads (valid = in_valid && in_ready).
- Bubbles are not collapsed. A bubble occupies its slot until it reaches the output.
- Results leave in issue order. No operation is dropped or duplicated.
- out_data, out_zero and out_valid hold stable while out_valid && !out_ready.

## Timing

- Reset, asynchronous with rst high: all stage valid bits 0, all data/shamt/op registers 0. Consequently out_valid = 0, out_data = 0, out_zero = 1, in_ready = 1.
- Reset mid-operation: all in-flight operations are discarded. No out_valid pulse occurs until new operations are issued after rst deasserts.
- Latency: an operation accepted at edge N appears with out_valid = 1 after edge N+SHW-1, provided no stall intervenes. For WIDTH = 32 it is visible 5 cycles after the in_valid cycle, counting the accept cycle as cycle 1.
- Each stall cycle (out_valid && !out_ready) adds exactly one cycle to the latency of every in-flight operation.
- Throughput: one operation per cycle while out_ready = 1.
- Simultaneous output transfer and input accept in the same cycle is legal and required: a full pipe with out_ready = 1 keeps in_ready = 1.
- in_ready depends combinationally on out_ready (one gate). This is the only combinational input-to-output path.
- in_shamt values ≥ WIDTH are unrepresentable by construction. Every SHW-bit value is legal.

## Test plan

- Reset: assert rst asynchronously mid-cycle → out_valid = 0, out_zero = 1, in_ready = 1 immediately, without waiting for a clock edge.
- Basic modes (WIDTH = 32, out_ready = 1), each result arriving 5 cycles after its issue cycle:
  - SLL 0x0000_0001 by 31 → 0x8000_0000.
  - SRL 0x8000_0000 by 4 → 0x0800_0000.
  - SRA 0x8000_0000 by 4 → 0xF800_0000.
  - ROL 0x8000_0001 by 1 → 0x0000_0003.
  - SLL 0xFFFF_FFFF by 0 → 0xFFFF_FFFF.
- Zero flag: SRL 0x0000_000F by 4 → out_data = 0, out_zero = 1.
- Backpressure: issue 8 back-to-back ops with in_data = 1..8 (SLL by 1); hold out_ready low for 3 cycles once the first result is valid.
  - in_ready is low for exactly those 3 cycles.
  - Outputs 2, 4, ..., 16 arrive in order, with none lost or repeated.
  - out_data is stable throughout the stall.
- Reset mid-flight: issue 3 ops, then pulse rst for one cycle two cycles later → no out_valid appears afterwards until a new op is issued. That op then completes with correct data.
- Randomised check plus WIDTH = 8 build: 10k random ops with random in_valid/out_ready, compared against a reference model in all four modes; include an SRA of 0x80 by 7 → 0xFF.
